// File: rtl/rggen_bus_access_controller.sv
// Host-to-register-slice access controller: latches one host request, broadcasts it to
// all slices during BUSY, merges the completing slices' replies and returns a one-cycle response.
module rggen_bus_access_controller #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 1,
  parameter int TIMEOUT       = 0
)(
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_request_valid,
  input  logic [1:0]                     i_request_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_request_address,
  input  logic [BUS_WIDTH-1:0]           i_request_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_request_strobe,
  output logic                           o_request_ready,
  output logic [1:0]                     o_response_status,
  output logic [BUS_WIDTH-1:0]           o_response_read_data,
  output logic                           o_register_valid,
  output logic [1:0]                     o_register_access,
  output logic [ADDRESS_WIDTH-1:0]       o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int STROBE_WIDTH = BUS_WIDTH / 8;
  localparam int COUNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] STATUS_OKAY   = 2'b00;
  localparam logic [1:0] STATUS_SLVERR = 2'b10;
  localparam logic [1:0] STATUS_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RESPOND = 2'b10
  } state_e;

  state_e                     state_r;
  state_e                     state_next_s;

  logic [1:0]                 access_r;
  logic [ADDRESS_WIDTH-1:0]   address_r;
  logic [BUS_WIDTH-1:0]       write_data_r;
  logic [STROBE_WIDTH-1:0]    strobe_r;

  logic                       valid_r;
  logic                       ready_r;
  logic [1:0]                 status_r;
  logic [BUS_WIDTH-1:0]       read_data_r;

  logic [REGISTERS-1:0]       hit_s;
  logic                       any_active_s;
  logic                       any_hit_s;
  logic                       timeout_s;
  logic [1:0]                 hit_status_s;
  logic [BUS_WIDTH-1:0]       hit_data_s;
  logic [1:0]                 capture_status_s;
  logic [BUS_WIDTH-1:0]       capture_data_s;

  assign hit_s        = i_register_active & i_register_ready;
  assign any_active_s = |i_register_active;
  assign any_hit_s    = |hit_s;

  // OR-merge status and read data of every slice that is both active and ready.
  always_comb begin
    hit_status_s = STATUS_OKAY;
    hit_data_s   = '0;
    for (int k = 0; k < REGISTERS; k++) begin
      hit_status_s = hit_status_s | ({2{hit_s[k]}} & i_register_status[2*k+:2]);
      hit_data_s   = hit_data_s | ({BUS_WIDTH{hit_s[k]}} & i_register_read_data[BUS_WIDTH*k+:BUS_WIDTH]);
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      logic [COUNT_WIDTH-1:0] count_r;

      // Saturating BUSY-cycle counter; held at zero outside BUSY so each access starts fresh.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          count_r <= '0;
        end else if (state_r != BUSY) begin
          count_r <= '0;
        end else if (count_r != COUNT_WIDTH'(TIMEOUT)) begin
          count_r <= count_r + COUNT_WIDTH'(1);
        end
      end

      // The cycle whose increment would reach TIMEOUT is the last BUSY cycle.
      assign timeout_s = (state_r == BUSY) && (count_r == COUNT_WIDTH'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_s = 1'b0;
    end
  endgenerate

  // Next-state and response selection; a late ready beats the timeout in the same cycle.
  always_comb begin
    state_next_s     = state_r;
    capture_status_s = STATUS_OKAY;
    capture_data_s   = '0;
    case (state_r)
      IDLE: begin
        if (i_request_valid) begin
          state_next_s = BUSY;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (!any_active_s) begin
          state_next_s     = RESPOND;
          capture_status_s = STATUS_DECERR;
        end else if (any_hit_s) begin
          state_next_s     = RESPOND;
          capture_status_s = hit_status_s;
          capture_data_s   = hit_data_s;
        end else if (timeout_s) begin
          state_next_s     = RESPOND;
          capture_status_s = STATUS_SLVERR;
        end else begin
          state_next_s     = BUSY;
        end
      end
      RESPOND: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, registered handshake outputs and response; response regs are zero except in RESPOND.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      valid_r     <= 1'b0;
      ready_r     <= 1'b0;
      status_r    <= STATUS_OKAY;
      read_data_r <= '0;
    end else begin
      state_r     <= state_next_s;
      valid_r     <= (state_next_s == BUSY);
      ready_r     <= (state_next_s == RESPOND);
      status_r    <= capture_status_s;
      read_data_r <= capture_data_s;
    end
  end

  // Request payload is captured only on acceptance, so it stays stable through BUSY.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      access_r     <= 2'b00;
      address_r    <= '0;
      write_data_r <= '0;
      strobe_r     <= '0;
    end else if ((state_r == IDLE) && i_request_valid) begin
      access_r     <= i_request_access;
      address_r    <= i_request_address;
      write_data_r <= i_request_write_data;
      strobe_r     <= i_request_strobe;
    end
  end

  assign o_request_ready       = ready_r;
  assign o_response_status     = status_r;
  assign o_response_read_data  = read_data_r;
  assign o_register_valid      = valid_r;
  assign o_register_access     = access_r;
  assign o_register_address    = address_r;
  assign o_register_write_data = write_data_r;
  assign o_register_strobe     = strobe_r;

endmodule

// File: tb/tb_rggen_bus_access_controller.sv
// Directed self-checking bench for rggen_bus_access_controller (two slices, TIMEOUT=4).
module tb_rggen_bus_access_controller;

  localparam int AW = 8;
  localparam int BW = 32;
  localparam int NR = 2;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic [1:0]        req_access;
  logic [AW-1:0]     req_address;
  logic [BW-1:0]     req_write_data;
  logic [BW/8-1:0]   req_strobe;
  logic              request_ready;
  logic [1:0]        response_status;
  logic [BW-1:0]     response_read_data;
  logic              reg_valid;
  logic [1:0]        reg_access;
  logic [AW-1:0]     reg_address;
  logic [BW-1:0]     reg_write_data;
  logic [BW/8-1:0]   reg_strobe;
  logic [NR-1:0]     reg_active;
  logic [NR-1:0]     reg_ready;
  logic [2*NR-1:0]   reg_status;
  logic [BW*NR-1:0]  reg_read_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rggen_bus_access_controller #(
    .ADDRESS_WIDTH(AW), .BUS_WIDTH(BW), .REGISTERS(NR), .TIMEOUT(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_request_valid(req_valid), .i_request_access(req_access),
    .i_request_address(req_address), .i_request_write_data(req_write_data),
    .i_request_strobe(req_strobe),
    .o_request_ready(request_ready), .o_response_status(response_status),
    .o_response_read_data(response_read_data),
    .o_register_valid(reg_valid), .o_register_access(reg_access),
    .o_register_address(reg_address), .o_register_write_data(reg_write_data),
    .o_register_strobe(reg_strobe),
    .i_register_active(reg_active), .i_register_ready(reg_ready),
    .i_register_status(reg_status), .i_register_read_data(reg_read_data)
  );

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slices(input logic [1:0] act, input logic [1:0] rdy,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] s0, input logic [1:0] s1);
    reg_active    = act;
    reg_ready     = rdy;
    reg_read_data = {d1, d0};
    reg_status    = {s1, s0};
  endtask

  task automatic send(input logic [1:0] acc, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] strb);
    req_valid      = 1'b1;
    req_access     = acc;
    req_address    = addr;
    req_write_data = wd;
    req_strobe     = strb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic done;
    logic [8:0] pattern;

    rst_n = 1'b0;
    req_valid = 1'b0; req_access = 2'b00; req_address = '0; req_write_data = '0; req_strobe = '0;
    set_slices(2'b00, 2'b00, 32'h0, 32'h0, 2'b00, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check_value("reset_ready", request_ready, 1'b0);
    check_value("reset_status", response_status, 2'b00);
    check_value("reset_rvalid", reg_valid, 1'b0);
    check_value("reset_payload", {reg_access, reg_address, reg_write_data, reg_strobe}, 46'h0);

    // Read hit on slice 0, accepted on the first edge after reset release.
    rst_n = 1'b1;
    send(2'b10, 8'h10, 32'h0, 4'hF);
    set_slices(2'b01, 2'b01, 32'hCAFE_0001, 32'h0, 2'b00, 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    check_value("rd_rvalid", reg_valid, 1'b1);
    check_value("rd_raddr", reg_address, 8'h10);
    check_value("rd_racc", reg_access, 2'b10);
    check_value("rd_early_ready", request_ready, 1'b0);
    @(negedge clk);
    check_value("rd_ready", request_ready, 1'b1);
    check_value("rd_status", response_status, 2'b00);
    check_value("rd_data", response_read_data, 32'hCAFE_0001);
    check_value("rd_rvalid_off", reg_valid, 1'b0);
    @(negedge clk);
    check_value("rd_ready_pulse", request_ready, 1'b0);
    check_value("rd_data_idle", response_read_data, 32'h0);

    // Unmapped write -> DECERR.
    send(2'b11, 8'hF0, 32'h1234_5678, 4'b0110);
    set_slices(2'b00, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    check_value("dec_rvalid", reg_valid, 1'b1);
    check_value("dec_wdata", reg_write_data, 32'h1234_5678);
    check_value("dec_strobe", reg_strobe, 4'b0110);
    @(negedge clk);
    check_value("dec_ready", request_ready, 1'b1);
    check_value("dec_status", response_status, 2'b11);
    check_value("dec_data", response_read_data, 32'h0);
    check_value("dec_rvalid_off", reg_valid, 1'b0);
    @(negedge clk);

    // Posted write, slice active but never ready -> SLVERR after 4 BUSY cycles; payload must not follow the host.
    send(2'b01, 8'h44, 32'hAAAA_5555, 4'hF);
    set_slices(2'b01, 2'b00, 32'hDEAD_BEEF, 32'h0, 2'b00, 2'b00);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      req_valid   = 1'b0;
      req_address = 8'hEE;
      if (reg_valid) begin
        n++;
        check_value("to_raddr_stable", reg_address, 8'h44);
      end
      if (request_ready) done = 1'b1;
    end
    check_value("to_response_seen", done, 1'b1);
    check_value("to_busy_cycles", n, 4);
    check_value("to_status", response_status, 2'b10);
    check_value("to_data", response_read_data, 32'h0);
    check_value("to_racc", reg_access, 2'b01);
    @(negedge clk);

    // Ready arriving in the last BUSY cycle beats the timeout.
    send(2'b10, 8'h48, 32'h0, 4'hF);
    set_slices(2'b01, 2'b00, 32'hA5A5_0000, 32'h0, 2'b00, 2'b00);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reg_ready = 2'b01;
    check_value("late_rvalid", reg_valid, 1'b1);
    @(negedge clk);
    check_value("late_ready", request_ready, 1'b1);
    check_value("late_status", response_status, 2'b00);
    check_value("late_data", response_read_data, 32'hA5A5_0000);
    @(negedge clk);

    // Two slices active and ready -> OR-merged.
    send(2'b10, 8'h20, 32'h0, 4'hF);
    set_slices(2'b11, 2'b11, 32'h0000_0F00, 32'h0000_00F0, 2'b00, 2'b10);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_value("merge_ready", request_ready, 1'b1);
    check_value("merge_data", response_read_data, 32'h0000_0FF0);
    check_value("merge_status", response_status, 2'b10);
    @(negedge clk);

    // Both active, only slice 0 ready -> slice 1 excluded.
    send(2'b10, 8'h24, 32'h0, 4'hF);
    set_slices(2'b11, 2'b01, 32'h0000_0F00, 32'h0000_00F0, 2'b00, 2'b10);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_value("mask_data", response_read_data, 32'h0000_0F00);
    check_value("mask_status", response_status, 2'b00);
    @(negedge clk);

    // Reset during BUSY with valid held high.
    send(2'b10, 8'h30, 32'h0, 4'hF);
    set_slices(2'b01, 2'b00, 32'h1111_2222, 32'h0, 2'b10, 2'b00);
    @(negedge clk);
    check_value("rst_busy_rvalid", reg_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_value("rst_async_rvalid", reg_valid, 1'b0);
    check_value("rst_async_raddr", reg_address, 8'h00);
    check_value("rst_async_ready", request_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    req_address = 8'h34;
    set_slices(2'b01, 2'b01, 32'h5555_AAAA, 32'h0, 2'b00, 2'b00);
    check_value("rst_no_stale_ready", request_ready, 1'b0);
    @(negedge clk);
    check_value("rst_new_ready", request_ready, 1'b0);
    check_value("rst_new_rvalid", reg_valid, 1'b1);
    check_value("rst_new_raddr", reg_address, 8'h34);
    @(negedge clk);
    req_valid = 1'b0;
    check_value("rst_new_resp", request_ready, 1'b1);
    check_value("rst_new_data", response_read_data, 32'h5555_AAAA);
    @(negedge clk);

    // Valid held high: accesses every third cycle, each with the payload present at its acceptance.
    send(2'b11, 8'h20, 32'h0, 4'hF);
    set_slices(2'b01, 2'b01, 32'h0, 32'h0, 2'b00, 2'b00);
    pattern = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pattern[i] = reg_valid;
      if (i == 0) begin
        check_value("b2b_raddr0", reg_address, 8'h20);
        req_address = 8'h24;
      end
      if (i == 3) begin
        check_value("b2b_raddr1", reg_address, 8'h24);
        req_address = 8'h28;
      end
      if (i == 6) check_value("b2b_raddr2", reg_address, 8'h28);
    end
    req_valid = 1'b0;
    check_value("b2b_pattern", pattern, 9'b001_001_001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
